madison_galloway_project5: RTL and testbench
============================================

Name: madison_galloway_project5

Overview:
Single-intersection traffic-light controller. It is a Moore FSM with a dwell-time counter that drives one-hot red/yellow/green lamp outputs. The controller rests on red until enabled by start, then cycles green -> yellow -> red for as long as start stays high. It is a leaf block clocked by the system clock, and its lamp outputs feed the lamp drivers directly.

Parameters:
GREEN_CYCLES, 8, clock cycles spent in GREEN (must be >= 1)
YELLOW_CYCLES, 3, clock cycles spent in YELLOW (must be >= 1)
RED_CYCLES, 6, clock cycles spent in timed RED (must be >= 1)
CNT_W, 8, dwell counter width; must hold max(*_CYCLES)-1

Ports:
clk    input   1  system clock; all state changes on the rising edge
reset  input   1  synchronous, active-high reset
start  input   1  run enable, level-sensitive, sampled on rising clk
R      output  1  red lamp
Y      output  1  yellow lamp
G      output  1  green lamp

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset has priority over start. On any rising edge with reset=1:
  - state <= IDLE, counter <= 0.
  - Outputs become R=1, Y=0, G=0, valid after that edge.
  - Reset asserted in any state, including mid-dwell, aborts the dwell immediately.
- States (2-bit encoding), with outputs decoded from the state register (Moore, no combinational path from start):
  - IDLE: R=1, Y=0, G=0. Untimed wait.
  - GREEN: R=0, Y=0, G=1.
  - YELLOW: R=0, Y=1, G=0.
  - RED: R=1, Y=0, G=0. Timed.
- Invariant: exactly one of R/Y/G is 1 in every cycle after the first reset edge.
- Counter:
  - Cleared to 0 on every state entry.
  - Increments by 1 each cycle in a timed state.
  - A timed state is exited on the edge where counter == DUR-1, so each timed state lasts exactly DUR cycles.
  - Counter is held at 0 in IDLE and never wraps.
- Transitions (evaluated at each rising edge, reset=0):
  - IDLE: start=1 -> GREEN; otherwise stay in IDLE.
  - GREEN: after GREEN_CYCLES -> YELLOW. start is ignored.
  - YELLOW: after YELLOW_CYCLES -> RED. start is ignored.
  - RED: after RED_CYCLES, go to GREEN if start=1 at that edge, otherwise go to IDLE.
- Latency: start sampled high in IDLE at edge k gives G=1 from edge k, i.e. visible immediately after that edge.
- start deasserted mid-sequence: the current GREEN/YELLOW/RED sequence completes, then the block parks in IDLE (red).
- start held high: the sequence repeats indefinitely with period GREEN_CYCLES+YELLOW_CYCLES+RED_CYCLES.
- Single-cycle start pulse in IDLE: exactly one full G/Y/R sequence, then IDLE.
- Before the first reset edge, outputs are undefined; the bench must apply reset first.
- Illegal state encoding: the next state is IDLE.

Test Plan:
- Reset=1 for 2 clk edges, start=0, then reset=0 for 10 cycles -> R=1, Y=0, G=0 on every cycle; counter stays 0.
- After reset, raise start=1 and hold -> G=1 for 8 cycles, Y=1 for 3, R=1 for 6, then G=1 again; period 17 cycles; exactly one lamp high at all times.
- start=1 for a single cycle while IDLE -> one sequence of 8 G, 3 Y, 6 R, then R held indefinitely (IDLE) with no further G.
- start dropped to 0 at cycle 3 of GREEN -> GREEN still lasts 8 cycles, YELLOW 3, RED 6, then IDLE red; no re-entry to GREEN.
- Reset=1 for one edge during cycle 2 of YELLOW with start=1 -> next cycle R=1 (IDLE). After reset drops, G=1 one edge later because start=1. The new GREEN lasts a full 8 cycles, confirming the counter was cleared.
- Reset and start both high on the same edge in IDLE -> stays in IDLE (R=1); reset wins.

Source files
------------

// File: rtl/madison_galloway_project5.sv
// Traffic-light controller: Moore FSM with a dwell counter driving one-hot R/Y/G lamps.
// Parks on red in IDLE until start is high, then cycles green -> yellow -> red.
module madison_galloway_project5 #(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned RED_CYCLES    = 6,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic R,
    output logic Y,
    output logic G
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StRed    = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RedLast    = CNT_W'(RED_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Counter restarts at 0 on every state change, so each timed state lasts exactly DUR cycles.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (start) begin
                    w_state_next = StGreen;
                end
            end
            StGreen: begin
                if (r_cnt == GreenLast) begin
                    w_state_next = StYellow;
                    w_cnt_next   = '0;
                end
            end
            StYellow: begin
                if (r_cnt == YellowLast) begin
                    w_state_next = StRed;
                    w_cnt_next   = '0;
                end
            end
            StRed: begin
                if (r_cnt == RedLast) begin
                    w_state_next = start ? StGreen : StIdle;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        R = 1'b0;
        Y = 1'b0;
        G = 1'b0;
        case (r_state)
            StGreen:  G = 1'b1;
            StYellow: Y = 1'b1;
            default:  R = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_madison_galloway_project5.sv
// Directed bench for the traffic-light controller; lamps are compared as {R,Y,G}
// one cycle at a time against hand-derived phase lengths (8 green, 3 yellow, 6 red).
module tb_madison_galloway_project5;

    logic clk;
    logic reset;
    logic start;
    logic R;
    logic Y;
    logic G;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    madison_galloway_project5 #(
        .GREEN_CYCLES (8),
        .YELLOW_CYCLES(3),
        .RED_CYCLES   (6),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .R    (R),
        .Y    (Y),
        .G    (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample 1 time unit after the rising edge, then inputs may change for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {R, Y, G};
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed RYG=%b expected RYG=%b", tag, obs, exp);
        end
        n_tests++;
        assert ($countones(obs) == 1 && !$isunknown(obs))
        else begin
            n_fail++;
            $error("FAIL %s_onehot: observed RYG=%b expected exactly one lamp", tag, obs);
        end
    endtask

    // Advance n cycles, checking the lamp after each edge.
    task automatic run(input string tag, input logic [2:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s[%0d]", tag, i), exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;

        // Reset for two edges, then idle on red.
        tick();
        tick();
        check("reset", LampR);
        reset = 1'b0;
        run("idle_after_reset", LampR, 10);

        // start held: full period, then green again (period 17).
        start = 1'b1;
        run("hold_g1", LampG, 8);
        run("hold_y1", LampY, 3);
        run("hold_r1", LampR, 6);
        run("hold_g2_head", LampG, 3);

        // Drop start at cycle 3 of green: sequence completes, then IDLE.
        start = 1'b0;
        run("drop_g2_tail", LampG, 5);
        run("drop_y2", LampY, 3);
        run("drop_r2", LampR, 6);
        run("drop_idle", LampR, 5);

        // Single-cycle start pulse: exactly one sequence, then IDLE.
        start = 1'b1;
        run("pulse_g_first", LampG, 1);
        start = 1'b0;
        run("pulse_g_rest", LampG, 7);
        run("pulse_y", LampY, 3);
        run("pulse_r", LampR, 6);
        run("pulse_idle", LampR, 8);

        // Reset during cycle 2 of yellow with start high.
        start = 1'b1;
        run("rst_pre_g", LampG, 8);
        run("rst_pre_y", LampY, 2);
        reset = 1'b1;
        run("rst_mid_yellow", LampR, 1);
        reset = 1'b0;
        run("rst_post_g", LampG, 8);
        start = 1'b0;
        run("rst_post_y", LampY, 3);
        run("rst_post_r", LampR, 6);
        run("rst_post_idle", LampR, 3);

        // Reset and start together in IDLE: reset wins.
        reset = 1'b1;
        start = 1'b1;
        run("rst_start_same_edge", LampR, 1);
        reset = 1'b0;
        start = 1'b0;
        run("rst_start_after", LampR, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
